// File: rtl/mvau_wl_pkg.sv
// Shared definitions for the MVAU runtime weight loader.
//   wl_state_t : loader FSM states (IDLE waits for a request, LOAD accepts
//                words, DONE marks the final write).
//   cnt_bw()   : counter width helper, max(1, clog2(n)), so that a single-PE
//                configuration still gets a 1-bit bank counter.
package mvau_wl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } wl_state_t;

  function automatic int cnt_bw(input int n);
    int bw;
    bw = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      bw++;
    end
    return (bw < 1) ? 1 : bw;
  endfunction

endpackage

// File: rtl/mvau_weight_loader.sv
// Runtime weight loader for the MVAU. Takes a stream of SIMD*TW-bit weight
// words and writes them into the per-PE weight bank write ports, bank 0
// first (address 0..WMEM_DEPTH-1), then bank 1, and so on. One load is
// exactly PE*WMEM_DEPTH words.
//
// Ports:
//   aclk, areset      clock (rising edge), asynchronous active-high reset
//   load_start        one-cycle request to begin a load, honoured in IDLE only
//   in_wgt_tdata      weight word
//   in_wgt_tvalid     source has a word
//   in_wgt_tready     loader accepts a word
//   wmem_we           one-hot bank write enable (registered)
//   wmem_waddr        bank write address (registered, holds when idle)
//   wmem_wdata        bank write data (registered, holds when idle)
//   load_busy         FSM is not in IDLE
//   load_done         one-cycle pulse aligned with the last write strobe
//
// Handshake: a word transfers on a rising edge where in_wgt_tvalid and
// in_wgt_tready are both high. in_wgt_tready depends on the FSM state only,
// never on in_wgt_tvalid, so the source may hold tvalid high at any time.
// Each transfer produces its bank write strobe on the following cycle.
module mvau_weight_loader
  import mvau_wl_pkg::*;
#(
  parameter int SIMD         = 2,
  parameter int TW           = 1,
  parameter int PE           = 2,
  parameter int WMEM_DEPTH   = 4,
  parameter int WMEM_ADDR_BW = 4
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    load_start,
  input  logic [SIMD*TW-1:0]      in_wgt_tdata,
  input  logic                    in_wgt_tvalid,
  output logic                    in_wgt_tready,
  output logic [PE-1:0]           wmem_we,
  output logic [WMEM_ADDR_BW-1:0] wmem_waddr,
  output logic [SIMD*TW-1:0]      wmem_wdata,
  output logic                    load_busy,
  output logic                    load_done
);

  localparam int PE_CNT_BW = cnt_bw(PE);
  localparam logic [PE_CNT_BW-1:0]    LAST_PE   = PE_CNT_BW'(PE - 1);
  localparam logic [WMEM_ADDR_BW-1:0] LAST_ADDR = WMEM_ADDR_BW'(WMEM_DEPTH - 1);

  wl_state_t               state;
  wl_state_t               state_next;
  logic [PE_CNT_BW-1:0]    pe_cnt;
  logic [WMEM_ADDR_BW-1:0] addr_cnt;
  logic                    hs;
  logic                    last_word;
  logic                    cnt_clear;
  logic [PE-1:0]           bank_sel;

  // Handshake is derived from state directly rather than from in_wgt_tready
  // so the next-state logic below does not read its own output.
  assign hs        = in_wgt_tvalid && (state == LOAD);
  assign last_word = (pe_cnt == LAST_PE) && (addr_cnt == LAST_ADDR);
  assign cnt_clear = ((state == IDLE) && load_start) || (state == DONE);

  always_comb begin
    bank_sel = '0;
    for (int i = 0; i < PE; i++) begin
      if (pe_cnt == PE_CNT_BW'(i)) bank_sel[i] = 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next state and state-decoded outputs
  always_comb begin
    state_next    = state;
    in_wgt_tready = 1'b0;
    load_busy     = 1'b1;
    load_done     = 1'b0;
    unique case (state)
      IDLE: begin
        load_busy = 1'b0;
        if (load_start) state_next = LOAD;
      end
      LOAD: begin
        in_wgt_tready = 1'b1;
        if (in_wgt_tvalid && last_word) state_next = DONE;
      end
      DONE: begin
        // The last write strobe lands in this cycle, so done pulses with it.
        load_done  = 1'b1;
        state_next = IDLE;
      end
      default: begin
        load_busy  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // Counters and registered write port
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      pe_cnt     <= '0;
      addr_cnt   <= '0;
      wmem_we    <= '0;
      wmem_waddr <= '0;
      wmem_wdata <= '0;
    end else begin
      wmem_we <= '0;
      if (hs) begin
        wmem_we    <= bank_sel;
        wmem_waddr <= addr_cnt;
        wmem_wdata <= in_wgt_tdata;
        if (addr_cnt == LAST_ADDR) begin
          addr_cnt <= '0;
          pe_cnt   <= pe_cnt + 1'b1;
        end else begin
          addr_cnt <= addr_cnt + 1'b1;
        end
      end
      // No handshake can occur in IDLE or DONE, so this never races the
      // increment above.
      if (cnt_clear) begin
        pe_cnt   <= '0;
        addr_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mvau_weight_loader.sv
// Self-checking bench for mvau_weight_loader (default parameters).
// Includes a per-bank RAM model with a 1-cycle registered read port for
// read-back of the loaded weights.
module tb_mvau_weight_loader;

  localparam int SIMD  = 2;
  localparam int TW    = 1;
  localparam int PE    = 2;
  localparam int DEPTH = 4;
  localparam int AB    = 4;
  localparam int W     = SIMD * TW;
  localparam int NW    = PE * DEPTH;
  localparam int EW    = 1 + PE + AB + W;

  logic          clk = 1'b0;
  logic          areset;
  logic          load_start;
  logic [W-1:0]  in_wgt_tdata;
  logic          in_wgt_tvalid;
  logic          in_wgt_tready;
  logic [PE-1:0] wmem_we;
  logic [AB-1:0] wmem_waddr;
  logic [W-1:0]  wmem_wdata;
  logic          load_busy;
  logic          load_done;

  int checks = 0;
  int errors = 0;

  // scoreboard: {last, bank one-hot, addr, data}
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] e;
  logic          exp_done;
  logic [PE-1:0] oh;
  int            hs_k = 0;
  int            wr_cnt = 0;
  int            done_cnt = 0;
  logic          mon_en = 1'b0;

  // bench-side model of bank contents
  logic [W-1:0] exp_mem [PE][DEPTH];
  int           sent_k = 0;

  // RAM model
  logic [W-1:0] mem [PE][1<<AB];
  int           rd_pe;
  logic [AB-1:0] rd_addr;
  logic [W-1:0] rd_data;

  always #5 clk = ~clk;

  mvau_weight_loader #(
    .SIMD(SIMD), .TW(TW), .PE(PE), .WMEM_DEPTH(DEPTH), .WMEM_ADDR_BW(AB)
  ) dut (
    .aclk(clk),
    .areset(areset),
    .load_start(load_start),
    .in_wgt_tdata(in_wgt_tdata),
    .in_wgt_tvalid(in_wgt_tvalid),
    .in_wgt_tready(in_wgt_tready),
    .wmem_we(wmem_we),
    .wmem_waddr(wmem_waddr),
    .wmem_wdata(wmem_wdata),
    .load_busy(load_busy),
    .load_done(load_done)
  );

  always @(posedge clk) begin
    for (int i = 0; i < PE; i++) begin
      if (wmem_we[i] === 1'b1) mem[i][wmem_waddr] <= wmem_wdata;
    end
    rd_data <= mem[rd_pe][rd_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop/compare write strobes, then record new handshakes.
  always @(negedge clk) begin
    if (mon_en && !areset) begin
      exp_done = 1'b0;
      if (wmem_we !== '0) begin
        if (exp_q.size() == 0) begin
          check("spurious_we", 32'(wmem_we), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("we",   32'(wmem_we),    32'(e[W+AB+PE-1:W+AB]));
          check("addr", 32'(wmem_waddr), 32'(e[W+AB-1:W]));
          check("data", 32'(wmem_wdata), 32'(e[W-1:0]));
          exp_done = e[EW-1];
          wr_cnt++;
        end
      end
      check("done_align", 32'(load_done), 32'(exp_done));
      if (load_done === 1'b1) done_cnt++;
      if (in_wgt_tvalid === 1'b1 && in_wgt_tready === 1'b1) begin
        oh = '0;
        oh[hs_k / DEPTH] = 1'b1;
        exp_q.push_back({(hs_k == NW - 1), oh, AB'(hs_k % DEPTH), in_wgt_tdata});
        hs_k++;
      end
    end
  end

  task automatic start_load();
    hs_k = 0; sent_k = 0; wr_cnt = 0; done_cnt = 0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("busy_after_start", 32'(load_busy), 32'd1);
    check("tready_in_load", 32'(in_wgt_tready), 32'd1);
  endtask

  // gaps idle cycles, then one word held until it is accepted
  task automatic push_word(input logic [W-1:0] d, input int gaps);
    bit ok;
    in_wgt_tvalid = 1'b0;
    for (int g = 0; g < gaps; g++) tick();
    in_wgt_tvalid = 1'b1;
    in_wgt_tdata  = d;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (in_wgt_tready === 1'b1) ok = 1'b1;
      tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout observed=not_accepted expected=accepted");
    end
    exp_mem[sent_k / DEPTH][sent_k % DEPTH] = d;
    sent_k++;
  endtask

  task automatic finish_load();
    in_wgt_tvalid = 1'b0;
    check("done_high", 32'(load_done), 32'd1);
    check("busy_in_done", 32'(load_busy), 32'd1);
    check("tready_in_done", 32'(in_wgt_tready), 32'd0);
    tick();
    check("done_low", 32'(load_done), 32'd0);
    check("busy_low", 32'(load_busy), 32'd0);
    check("tready_idle", 32'(in_wgt_tready), 32'd0);
    check("write_count", 32'(wr_cnt), 32'(NW));
    check("done_count", 32'(done_cnt), 32'd1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic readback();
    for (int p = 0; p < PE; p++) begin
      for (int a = 0; a < DEPTH; a++) begin
        rd_pe = p;
        rd_addr = AB'(a);
        tick();
        check("readback", 32'(rd_data), 32'(exp_mem[p][a]));
      end
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_tready", 32'(in_wgt_tready), 32'd0);
    check("rst_we",     32'(wmem_we),       32'd0);
    check("rst_waddr",  32'(wmem_waddr),    32'd0);
    check("rst_wdata",  32'(wmem_wdata),    32'd0);
    check("rst_busy",   32'(load_busy),     32'd0);
    check("rst_done",   32'(load_done),     32'd0);
  endtask

  initial begin
    logic [W-1:0] cont_data [NW];
    cont_data = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    areset = 1'b0; load_start = 1'b0; in_wgt_tvalid = 1'b0; in_wgt_tdata = '0;
    rd_pe = 0; rd_addr = '0;

    // asynchronous reset mid-cycle with active inputs
    #3;
    in_wgt_tvalid = 1'b1; in_wgt_tdata = 2'd3; load_start = 1'b1;
    areset = 1'b1;
    #1;
    check_reset_outputs();
    load_start = 1'b0; in_wgt_tvalid = 1'b0;
    tick(); tick();
    areset = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("tready_before_start", 32'(in_wgt_tready), 32'd0);
    end

    // continuous load
    start_load();
    for (int i = 0; i < NW; i++) push_word(cont_data[i], 0);
    finish_load();
    readback();

    // bubbles: 1,0,0,1,0,0,...
    start_load();
    for (int i = 0; i < NW; i++) push_word(W'($urandom_range(0, 3)), (i == 0) ? 0 : 2);
    finish_load();
    readback();

    // load_start during LOAD is ignored
    start_load();
    for (int i = 0; i < 3; i++) push_word(W'($urandom_range(0, 3)), 0);
    in_wgt_tvalid = 1'b0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("busy_ignore_start", 32'(load_busy), 32'd1);
    for (int i = 3; i < NW; i++) push_word(W'($urandom_range(0, 3)), 0);
    finish_load();
    readback();

    // reset after 3 words, then a full reload of 2s
    start_load();
    for (int i = 0; i < 3; i++) push_word(W'($urandom_range(0, 3)), 0);
    in_wgt_tvalid = 1'b0;
    tick();
    #2;
    areset = 1'b1;
    #1;
    check_reset_outputs();
    exp_q.delete();
    tick(); tick();
    areset = 1'b0;
    tick();
    check("tready_after_reset", 32'(in_wgt_tready), 32'd0);
    start_load();
    for (int i = 0; i < NW; i++) push_word(2'd2, 0);
    finish_load();
    readback();

    // tvalid in IDLE is not accepted
    in_wgt_tvalid = 1'b1;
    in_wgt_tdata  = 2'd3;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_tready", 32'(in_wgt_tready), 32'd0);
      check("idle_we", 32'(wmem_we), 32'd0);
    end
    start_load();
    push_word(2'd3, 0);
    for (int i = 1; i < NW; i++) push_word(W'(i % 4), 0);
    finish_load();
    readback();

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
